sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_arb_pkg.sv | 27 ++
 rtl/sram_arb_rr.sv | 46 ++++
 rtl/sram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared FSM state encoding, default bus widths and grant-owner
//            encoding for the SRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int unsigned C_DEFAULT_AW = 19;
  localparam int unsigned C_DEFAULT_DW = 16;
  localparam int unsigned C_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_t;

endpackage
`default_nettype wire

// File: rtl/sram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_rr
// Brief    : Two-input write/read grant decision with last-grant register.
//            SRAM_ARB_WRITE_PRIO_EN: write always wins a simultaneous request.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_grant_en,
  input  logic i_wr_req,
  input  logic i_rd_req,
  output logic o_gnt_valid,
  output gnt_t o_gnt_owner
);

  gnt_t r_last;

  always_comb begin
    o_gnt_valid = i_wr_req | i_rd_req;
    o_gnt_owner = GNT_RD;
    if (i_wr_req && i_rd_req) begin
`ifdef SRAM_ARB_WRITE_PRIO_EN
      o_gnt_owner = GNT_WR;
`else
      o_gnt_owner = (r_last == GNT_RD) ? GNT_WR : GNT_RD;
`endif
    end else if (i_wr_req) begin
      o_gnt_owner = GNT_WR;
    end
  end

  // Reset to "read" so a write wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= GNT_RD;
    end else if (i_grant_en && o_gnt_valid) begin
      r_last <= o_gnt_owner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Shares one asynchronous SRAM between a write and a read requester
//            with a SETUP/ACCESS/DONE strobe sequence per word.
//            SRAM_ARB_WRITE_PRIO_EN: write always wins simultaneous requests.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned AW            = C_DEFAULT_AW,
  parameter int unsigned DW            = C_DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_done,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_done,
  output logic          busy,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(ACCESS_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [C_CNT_W-1:0]  w_cnt_nxt;
  gnt_t                r_dir;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW-1:0]       r_rdata;
  logic                w_idle;
  logic                w_gnt_valid;
  gnt_t                w_gnt_owner;
  logic                w_grant;
  logic                w_last_access;
  logic                w_is_wr;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_grant       = w_idle & w_gnt_valid;
  assign w_last_access = (r_state == ST_ACCESS) && (r_cnt == C_LAST_CNT);
  assign w_is_wr       = (r_dir == GNT_WR);

  sram_arb_rr u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_grant_en  (w_idle),
    .i_wr_req    (wr_req),
    .i_rd_req    (rd_req),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_owner (w_gnt_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b1;
    sram_ce_n   = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_dq_oe  = w_is_wr;
    wr_done     = 1'b0;
    rd_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy       = 1'b0;
        sram_ce_n  = 1'b1;
        sram_dq_oe = 1'b0;
        if (w_gnt_valid) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
        w_cnt_nxt   = '0;
      end
      ST_ACCESS: begin
        sram_we_n = ~w_is_wr;
        sram_oe_n = w_is_wr;
        if (r_cnt == C_LAST_CNT) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        // Read keeps OE low one extra cycle as data hold; write keeps DQ driven.
        sram_oe_n   = w_is_wr;
        wr_done     = w_is_wr;
        rd_done     = ~w_is_wr;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir   <= GNT_RD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_dir  <= w_gnt_owner;
        r_addr <= (w_gnt_owner == GNT_WR) ? wr_addr : rd_addr;
        if (w_gnt_owner == GNT_WR) begin
          r_wdata <= wr_data;
        end
      end
      if (w_last_access && !w_is_wr) begin
        r_rdata <= sram_dq_i;
      end
    end
  end

  assign sram_addr = r_addr;
  assign sram_dq_o = r_wdata;
  assign rd_data   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Self-checking bench: vector table, corner sequences and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

  localparam int AC  = 2;
  localparam int AC1 = 1;

  typedef struct {
    logic        is_wr;
    logic [18:0] addr;
    logic [15:0] data;
    logic        preload;
    logic [15:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [18:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_done, rd_done, busy, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] rd_data, sram_dq_o, sram_dq_i;
  logic [18:0] sram_addr;

  logic        wr_req1 = 1'b0, rd_req1 = 1'b0;
  logic [18:0] wr_addr1 = '0, rd_addr1 = '0;
  logic [15:0] wr_data1 = '0;
  logic        wr_done1, rd_done1, busy1, sram_dq_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1;
  logic [15:0] rd_data1, sram_dq_o1, sram_dq_i1;
  logic [18:0] sram_addr1;

  sram_port_arbiter #(.ACCESS_CYCLES(AC), .AW(19), .DW(16)) u_dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .busy(busy), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_port_arbiter #(.ACCESS_CYCLES(AC1), .AW(19), .DW(16)) u_dut1 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_done(wr_done1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_done(rd_done1),
    .busy(busy1), .sram_addr(sram_addr1), .sram_dq_o(sram_dq_o1), .sram_dq_oe(sram_dq_oe1),
    .sram_dq_i(sram_dq_i1), .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1)
  );

  // Behavioural SRAMs: write on a low WE at the clock edge, read data refreshed mid-cycle.
  logic [15:0] mem0 [logic [18:0]];
  logic [15:0] mem1 [logic [18:0]];
  logic        pre_en = 1'b0;
  logic [18:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem0[pre_addr] = pre_data;
    if (!sram_we_n) mem0[sram_addr] = sram_dq_o;
  end
  always @(negedge clk) sram_dq_i = mem0.exists(sram_addr) ? mem0[sram_addr] : 16'h0;

  always @(posedge clk) if (!sram_we_n1) mem1[sram_addr1] = sram_dq_o1;
  always @(negedge clk) sram_dq_i1 = mem1.exists(sram_addr1) ? mem1[sram_addr1] : 16'h0;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] m_mem [logic [18:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle also checks strobe exclusivity on both instances.
  task automatic tick();
    @(negedge clk);
    n_cmp++;
    if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n) ||
        (!sram_we_n1 && !sram_oe_n1) || (sram_dq_oe1 && !sram_oe_n1)) begin
      n_err++;
      $display("FAIL strobe_exclusive: actual we_n=%b oe_n=%b dq_oe=%b we_n1=%b oe_n1=%b dq_oe1=%b required no overlap (t=%0t)",
               sram_we_n, sram_oe_n, sram_dq_oe, sram_we_n1, sram_oe_n1, sram_dq_oe1, $time);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_single(input vec_t v, input string tag);
    int lat;
    int strobes;
    bit seen;
    lat = 0; strobes = 0; seen = 1'b0;
    if (!v.is_wr && v.preload) begin
      pre_addr = v.addr; pre_data = v.data; pre_en = 1'b1;
    end
    wr_addr = v.addr; rd_addr = v.addr; wr_data = v.data;
    wr_req = v.is_wr; rd_req = !v.is_wr;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (v.is_wr ? !sram_we_n : !sram_oe_n) begin
        strobes++;
        check({tag, " strobe addr"}, 32'(sram_addr), 32'(v.addr));
        if (v.is_wr) check({tag, " strobe dq"}, 32'(sram_dq_o), 32'(v.data));
        else         check({tag, " read dq_oe"}, 32'(sram_dq_oe), 32'd0);
      end
      seen = wr_done | rd_done;
    end
    wr_req = 1'b0; rd_req = 1'b0; pre_en = 1'b0;
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(AC + 2));
    check({tag, " wr_done"}, 32'(wr_done), 32'(v.is_wr));
    check({tag, " rd_done"}, 32'(rd_done), 32'(!v.is_wr));
    check({tag, " strobe cycles"}, 32'(strobes), v.is_wr ? 32'(AC) : 32'(AC + 1));
    if (!v.is_wr) check({tag, " rd_data"}, 32'(rd_data), 32'(v.exp_rd));
    tick();
    check({tag, " idle after"}, 32'(busy), 32'd0);
  endtask

  // Transaction-level model: a grant in idle cycle g yields done in cycle g+AC+2.
  task automatic run_random(input int n);
    int g_at, done_at;
    bit m_last, m_own, own, wp, rp;
    logic [18:0] m_addr, wa, ra;
    logic [15:0] m_data, wd, exp_rd;
    g_at = -1; done_at = -1; m_last = 1'b1; m_own = 1'b0;
    wp = 1'b0; rp = 1'b0; wa = '0; ra = '0; wd = '0; m_addr = '0; m_data = '0;
    for (int cyc = 0; cyc < n; cyc++) begin
      tick();
      check("rnd busy", 32'(busy), 32'((cyc > g_at) && (cyc <= done_at)));
      check("rnd wr_done", 32'(wr_done), 32'((cyc == done_at) && !m_own));
      check("rnd rd_done", 32'(rd_done), 32'((cyc == done_at) && m_own));
      if (cyc == done_at) begin
        if (m_own) begin
          exp_rd = m_mem.exists(m_addr) ? m_mem[m_addr] : 16'h0;
          check("rnd rd_data", 32'(rd_data), 32'(exp_rd));
          rp = 1'b0;
        end else begin
          m_mem[m_addr] = m_data;
          wp = 1'b0;
        end
      end
      if (!wp && $urandom_range(2) == 0) begin
        wp = 1'b1; wa = 19'h100 + 19'($urandom_range(7)); wd = 16'($urandom);
      end
      if (!rp && $urandom_range(2) == 0) begin
        rp = 1'b1; ra = 19'h100 + 19'($urandom_range(7));
      end
      wr_req = wp; rd_req = rp;
      // Owner's inputs are scrambled while in flight; the latched copy must be used.
      if (cyc > g_at && cyc < done_at && !m_own) begin
        wr_addr = 19'($urandom); wr_data = 16'($urandom);
      end else begin
        wr_addr = wa; wr_data = wd;
      end
      if (cyc > g_at && cyc < done_at && m_own) rd_addr = 19'($urandom);
      else                                       rd_addr = ra;
      if (cyc > done_at && (wp || rp)) begin
`ifdef SRAM_ARB_WRITE_PRIO_EN
        own = (wp && rp) ? 1'b0 : !wp;
`else
        own = (wp && rp) ? !m_last : !wp;
`endif
        m_last = own; m_own = own;
        m_addr = own ? ra : wa;
        m_data = wd;
        g_at = cyc; done_at = cyc + AC + 2;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < AC + 4; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    bit   exp_ord[4];
    bit   got_ord[4];
    int   nd, lat;
    bit   seen;

    vecs[0] = '{1'b1, 19'h00005, 16'hA55A, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 19'h7FFFF, 16'h1234, 1'b1, 16'h1234};
    vecs[2] = '{1'b0, 19'h00005, 16'h0000, 1'b0, 16'hA55A};
    vecs[3] = '{1'b1, 19'h7FFFF, 16'hFFFF, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 19'h7FFFF, 16'h0000, 1'b0, 16'hFFFF};
    vecs[5] = '{1'b1, 19'h00000, 16'h0001, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 19'h00000, 16'h0000, 1'b0, 16'h0001};

    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset ce_n", 32'(sram_ce_n), 32'd1);
    check("reset we_n", 32'(sram_we_n), 32'd1);
    check("reset oe_n", 32'(sram_oe_n), 32'd1);
    check("reset dq_oe", 32'(sram_dq_oe), 32'd0);
    check("reset addr", 32'(sram_addr), 32'd0);
    check("reset dq_o", 32'(sram_dq_o), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset dones", 32'({wr_done, rd_done}), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held continuously for four transactions.
    rst_pulse();
`ifdef SRAM_ARB_WRITE_PRIO_EN
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    got_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
    wr_addr = 19'h10; wr_data = 16'h1111; rd_addr = 19'h20;
    wr_req = 1'b1; rd_req = 1'b1;
    nd = 0;
    for (int c = 0; c < 40 && nd < 4; c++) begin
      tick();
      if (wr_done || rd_done) begin
        got_ord[nd] = rd_done;
        nd++;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("tie count", 32'(nd), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("tie order%0d", i), 32'(got_ord[i]), 32'(exp_ord[i]));
    tick();

    // Reset in the middle of a write strobe.
    wr_addr = 19'h33; wr_data = 16'h5A5A; wr_req = 1'b1;
    tick();
    tick();
    check("abort pre we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b1; wr_req = 1'b0;
    #1;
    check("abort we_n", 32'(sram_we_n), 32'd1);
    check("abort dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort ce_n", 32'(sram_ce_n), 32'd1);
    check("abort addr", 32'(sram_addr), 32'd0);
    check("abort wr_done", 32'(wr_done), 32'd0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wr_done) nd++;
    end
    check("abort no done", 32'(nd), 32'd0);
    run_single('{1'b1, 19'h00033, 16'hC3C3, 1'b0, 16'h0000}, "post_rst_wr");
    run_single('{1'b0, 19'h00033, 16'h0000, 1'b0, 16'hC3C3}, "post_rst_rd");

    // Write then read the same word on the ACCESS_CYCLES=1 instance.
    wr_addr1 = 19'h42; wr_data1 = 16'hBEEF; wr_req1 = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 12) begin
      tick();
      lat++;
      seen = wr_done1;
    end
    check("b2b wr latency", 32'(lat), 32'(AC1 + 2));
    wr_req1 = 1'b0; rd_addr1 = 19'h42; rd_req1 = 1'b1;
    tick();
    check("b2b idle busy", 32'(busy1), 32'd0);
    check("b2b idle dq_oe", 32'(sram_dq_oe1), 32'd0);
    check("b2b idle ce_n", 32'(sram_ce_n1), 32'd1);
    tick();
    check("b2b setup busy", 32'(busy1), 32'd1);
    check("b2b setup dq_oe", 32'(sram_dq_oe1), 32'd0);
    lat = 1; seen = 1'b0;
    while (!seen && lat < 12) begin
      tick();
      lat++;
      seen = rd_done1;
    end
    rd_req1 = 1'b0;
    check("b2b rd latency", 32'(lat), 32'(AC1 + 2));
    check("b2b rd_data", 32'(rd_data1), 32'h0000BEEF);
    tick();

    rst_pulse();
    run_random(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
